// File: rtl/jpu_impl_pkg.sv
// Shared constants, state encodings and probe layout for the jpu board wrapper.
package jpu_impl_pkg;

  localparam int CLKS_PER_BIT_DEF = 868;

  localparam int BANNER_LEN = 5;
  // Index 0 is sent first: "JPU\r\n".
  localparam logic [BANNER_LEN-1:0][7:0] BANNER = {8'h0A, 8'h0D, 8'h55, 8'h50, 8'h4A};

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  localparam int PRB_TX_BYTE     = 0;
  localparam int PRB_LAST_RX     = 8;
  localparam int PRB_TX_BUSY     = 16;
  localparam int PRB_RX_VALID    = 17;
  localparam int PRB_FRAME_ERR   = 18;
  localparam int PRB_OVF         = 19;
  localparam int PRB_BANNER_DONE = 20;

  function automatic logic [7:0] banner_byte(input logic [2:0] idx);
    return (int'(idx) < BANNER_LEN) ? BANNER[idx] : 8'h00;
  endfunction

endpackage

// File: rtl/jpu_impl_top_uart.sv
// 8N1 UART TX and RX engines; TX accepts a byte combinationally from IDLE or the
// last stop-bit cycle so bytes go out back-to-back, RX expects an already-synchronized line.
module jpu_uart
  import jpu_impl_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       tx_take,
  output logic       tx_busy,
  output logic [7:0] tx_byte,
  output logic       txd,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  tx_state_t     tx_state, tx_state_nxt;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic          txd_nxt;
  logic          tx_cnt_done;

  assign tx_cnt_done = (tx_cnt == BIT_LAST);
  assign tx_busy     = (tx_state != TX_IDLE);

  always_comb begin
    tx_state_nxt = tx_state;
    txd_nxt      = txd;
    tx_take      = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (tx_req) begin
          tx_state_nxt = TX_START;
          txd_nxt      = 1'b0;
          tx_take      = 1'b1;
        end
      end
      TX_START: begin
        if (tx_cnt_done) begin
          tx_state_nxt = TX_DATA;
          txd_nxt      = tx_byte[0];
        end
      end
      TX_DATA: begin
        if (tx_cnt_done) begin
          if (tx_bit == 3'd7) begin
            tx_state_nxt = TX_STOP;
            txd_nxt      = 1'b1;
          end else begin
            txd_nxt = tx_byte[tx_bit + 3'd1];
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt_done) begin
          if (tx_req) begin
            tx_state_nxt = TX_START;
            txd_nxt      = 1'b0;
            tx_take      = 1'b1;
          end else begin
            tx_state_nxt = TX_IDLE;
          end
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_byte  <= '0;
      txd      <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      txd      <= txd_nxt;
      tx_cnt   <= (tx_state == TX_IDLE || tx_cnt_done) ? '0 : tx_cnt + CW'(1);
      if (tx_state == TX_DATA && tx_cnt_done) tx_bit <= tx_bit + 3'd1;
      if (tx_take) tx_byte <= tx_data;
    end
  end

  rx_state_t     rx_state, rx_state_nxt;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_prev;
  logic          rx_cnt_done;

  assign rx_cnt_done = (rx_cnt == BIT_LAST);

  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      RX_IDLE:      if (rx_prev && !rx) rx_state_nxt = RX_START;
      RX_START:     if (rx_cnt == HALF_LAST) rx_state_nxt = rx ? RX_IDLE : RX_DATA;
      RX_DATA:      if (rx_cnt_done && rx_bit == 3'd7) rx_state_nxt = RX_STOP;
      RX_STOP:      if (rx_cnt_done) rx_state_nxt = rx ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (rx) rx_state_nxt = RX_IDLE;
      default:      rx_state_nxt = RX_IDLE;
    endcase
  end

  // Counter restarts on every state change, so the START half-bit wait puts
  // all following full-bit samples at mid-bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_sh     <= '0;
      rx_prev   <= 1'b1;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      frame_err <= 1'b0;
    end else begin
      rx_state  <= rx_state_nxt;
      rx_prev   <= rx;
      rx_valid  <= (rx_state == RX_STOP) && rx_cnt_done && rx;
      frame_err <= (rx_state == RX_STOP) && rx_cnt_done && !rx;
      rx_cnt    <= (rx_state_nxt != rx_state || rx_cnt_done ||
                    rx_state == RX_IDLE || rx_state == RX_WAIT_HIGH) ? '0 : rx_cnt + CW'(1);
      if (rx_state == RX_DATA && rx_cnt_done) begin
        rx_sh  <= {rx, rx_sh[7:1]};
        rx_bit <= rx_bit + 3'd1;
      end
      if (rx_state == RX_STOP && rx_cnt_done && rx) rx_data <= rx_sh;
    end
  end

endmodule

// File: rtl/jpu_impl_top.sv
// Board wrapper: input synchronizers, boot banner then UART echo with a 1-entry holding
// register, sticky error flags, heartbeat, LED and ILA probe muxing.
module jpu_impl_top
  import jpu_impl_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int HB_BIT       = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  user_btn,
  input  logic [3:0]  user_sw,
  output logic [7:0]  status_led,
  output logic        uart_rxd_out,
  input  logic        uart_txd_in,
  output logic [31:0] ila_probe
);

  logic [3:0] btn_meta, btn_s, sw_meta, sw_s;
  logic       rx_meta, rx_s;

  // RX line syncs reset to idle-high so a line held low from reset reads as a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta <= '0;
      btn_s    <= '0;
      sw_meta  <= '0;
      sw_s     <= '0;
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
    end else begin
      btn_meta <= user_btn;
      btn_s    <= btn_meta;
      sw_meta  <= user_sw;
      sw_s     <= sw_meta;
      rx_meta  <= uart_txd_in;
      rx_s     <= rx_meta;
    end
  end

  logic       sw_unused;
  assign sw_unused = ^sw_s[3:1];

  logic       tx_req, tx_take, tx_busy;
  logic [7:0] tx_data, tx_byte;
  logic       rx_valid, frame_err;
  logic [7:0] rx_data;

  jpu_uart #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk       (clk),
    .rst       (rst),
    .tx_req    (tx_req),
    .tx_data   (tx_data),
    .tx_take   (tx_take),
    .tx_busy   (tx_busy),
    .tx_byte   (tx_byte),
    .txd       (uart_rxd_out),
    .rx        (rx_s),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .frame_err (frame_err)
  );

  logic [2:0]      banner_idx;
  logic            banner_done;
  logic            hold_full;
  logic [7:0]      hold_byte;
  logic [7:0]      last_rx;
  logic            frame_err_s, ovf_s;
  logic [HB_BIT:0] hb;
  logic            bypass, hold_load, ovf;

  assign banner_done = (banner_idx == 3'(BANNER_LEN));
  // An idle TX with an empty holding register sends the fresh RX byte directly.
  assign bypass    = banner_done && !hold_full && rx_valid;
  assign tx_req    = !banner_done || hold_full || rx_valid;
  assign tx_data   = !banner_done ? banner_byte(banner_idx) :
                     hold_full    ? hold_byte : rx_data;
  assign ovf       = rx_valid && hold_full;
  assign hold_load = rx_valid && !hold_full && !(bypass && tx_take);

  always_ff @(posedge clk) begin
    if (rst) begin
      banner_idx  <= '0;
      hold_full   <= 1'b0;
      hold_byte   <= '0;
      last_rx     <= '0;
      frame_err_s <= 1'b0;
      ovf_s       <= 1'b0;
      hb          <= '0;
    end else begin
      hb <= hb + 1'b1;
      if (tx_take && !banner_done) banner_idx <= banner_idx + 3'd1;
      if (hold_load) begin
        hold_full <= 1'b1;
        hold_byte <= rx_data;
      end else if (tx_take && banner_done && hold_full) begin
        hold_full <= 1'b0;
      end
      if (rx_valid) last_rx <= rx_data;
      if (frame_err)     frame_err_s <= 1'b1;
      else if (btn_s[0]) frame_err_s <= 1'b0;
      if (ovf)           ovf_s <= 1'b1;
      else if (btn_s[0]) ovf_s <= 1'b0;
    end
  end

  assign status_led = sw_s[0] ? last_rx : {hb[HB_BIT], frame_err_s, ovf_s, tx_busy, btn_s};

  always_comb begin
    ila_probe                       = '0;
    ila_probe[PRB_TX_BYTE +: 8]     = tx_byte;
    ila_probe[PRB_LAST_RX +: 8]     = last_rx;
    ila_probe[PRB_TX_BUSY]          = tx_busy;
    ila_probe[PRB_RX_VALID]         = rx_valid;
    ila_probe[PRB_FRAME_ERR]        = frame_err;
    ila_probe[PRB_OVF]              = ovf;
    ila_probe[PRB_BANNER_DONE]      = banner_done;
  end

endmodule

// File: tb/tb_jpu_impl_top.sv
// Scoreboard bench for jpu_impl_top: decodes the TX line against queued expected bytes.
module tb_jpu_impl_top;

  localparam int CPB = 8;
  localparam int HB  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  user_btn = '0;
  logic [3:0]  user_sw = '0;
  logic        uart_txd_in = 1'b1;
  logic [7:0]  status_led;
  logic        uart_rxd_out;
  logic [31:0] ila_probe;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rxv_cnt = 0, ferr_cnt = 0, ovf_cnt = 0, rxv_cyc = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  jpu_impl_top #(
    .CLKS_PER_BIT(CPB),
    .HB_BIT(HB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .user_btn     (user_btn),
    .user_sw      (user_sw),
    .status_led   (status_led),
    .uart_rxd_out (uart_rxd_out),
    .uart_txd_in  (uart_txd_in),
    .ila_probe    (ila_probe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ila_probe[17]) begin
      rxv_cnt++;
      rxv_cyc = cyc;
    end
    if (ila_probe[18]) ferr_cnt++;
    if (ila_probe[19]) ovf_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // TX line decoder: samples mid-bit, compares against the scoreboard queue.
  initial begin : tx_mon
    logic       prev;
    logic [7:0] b;
    logic [7:0] e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev && !uart_rxd_out && !rst) begin
        start_q.push_back(cyc);
        repeat (CPB / 2) @(negedge clk);
        chk("tx_start_bit", 32'(uart_rxd_out), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_rxd_out;
        end
        repeat (CPB) @(negedge clk);
        chk("tx_stop_bit", 32'(uart_rxd_out), 32'd1);
        chk("tx_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("tx_byte", 32'(b), 32'(e));
        end
      end
      prev = uart_rxd_out;
    end
  end

  task automatic do_reset(input logic line, output int rel);
    @(negedge clk);
    rst = 1'b1;
    uart_txd_in = line;
    user_btn = '0;
    user_sw = '0;
    repeat (2) @(negedge clk);
    chk("rst_txd", 32'(uart_rxd_out), 32'd1);
    chk("rst_led", 32'(status_led), 32'd0);
    chk("rst_probe", ila_probe, 32'd0);
    exp_q.delete();
    start_q.delete();
    exp_q.push_back(8'h4A);
    exp_q.push_back(8'h50);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    rst = 1'b0;
    rel = cyc + 1;
  endtask

  task automatic wait_idle(input int maxc, input string tag);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !ila_probe[16] && uart_rxd_out) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    uart_txd_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_txd_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_txd_in = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   rel, fbase, rbase, obase, tog;
    logic v, nv;

    // Reset, then the boot banner.
    do_reset(1'b1, rel);
    wait_idle(1500, "banner_wait");
    chk("banner_starts", 32'(start_q.size()), 32'd5);
    if (start_q.size() > 0) chk("first_start_cyc", start_q[0], rel);
    for (int i = 1; i < start_q.size(); i++)
      chk("banner_gap", start_q[i] - start_q[i-1], 10 * CPB);
    repeat (20) @(negedge clk);
    chk("banner_done_bit", 32'(ila_probe[20]), 32'd1);
    chk("idle_high", 32'(uart_rxd_out), 32'd1);

    // Echo of a single byte.
    exp_q.push_back(8'hA5);
    send_byte(8'hA5);
    wait_idle(500, "echo_wait");
    chk("echo_latency", start_q[$] - rxv_cyc, 32'd1);
    user_sw = 4'b0001;
    repeat (4) @(negedge clk);
    chk("led_last_rx", 32'(status_led), 32'hA5);
    chk("probe_last_rx", 32'(ila_probe[15:8]), 32'hA5);

    // RX line stuck low from reset.
    do_reset(1'b0, rel);
    fbase = ferr_cnt;
    rbase = rxv_cnt;
    wait_idle(1500, "stuck_wait");
    repeat (100) @(negedge clk);
    chk("ferr_pulses", ferr_cnt - fbase, 32'd1);
    chk("stuck_no_rxv", rxv_cnt - rbase, 32'd0);
    chk("ferr_sticky_led", 32'(status_led[6]), 32'd1);
    user_btn = 4'b0001;
    repeat (4) @(negedge clk);
    user_btn = 4'b0000;
    repeat (4) @(negedge clk);
    chk("ferr_cleared", 32'(status_led[6]), 32'd0);
    uart_txd_in = 1'b1;
    repeat (20) @(negedge clk);
    chk("ferr_after_release", ferr_cnt - fbase, 32'd1);

    // Three bytes during the banner: first held and echoed, rest dropped.
    do_reset(1'b1, rel);
    obase = ovf_cnt;
    rbase = rxv_cnt;
    exp_q.push_back(8'h11);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    wait_idle(1500, "ovf_wait");
    repeat (200) @(negedge clk);
    chk("ovf_pulses", ovf_cnt - obase, 32'd2);
    chk("ovf_rxv", rxv_cnt - rbase, 32'd3);
    chk("ovf_sticky_led", 32'(status_led[5]), 32'd1);
    chk("ovf_last_rx", 32'(ila_probe[15:8]), 32'h33);
    chk("ovf_q_drained", 32'(exp_q.size()), 32'd0);

    // Heartbeat on LED 7 toggles every 2**HB cycles.
    for (int i = 0; i < 4; i++) begin
      v = status_led[7];
      nv = ~v;
      repeat (8) @(negedge clk);
      chk("hb_toggle", 32'(status_led[7]), 32'(nv));
    end
    tog = 0;
    v = status_led[7];
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (status_led[7] != v) tog++;
      v = status_led[7];
    end
    chk("hb_toggles_64", tog, 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jpu_impl_top.md
# jpu_impl_top

Board-level implementation wrapper for the jpu FPGA build, instantiated as `jpu_impl`. It connects the on-board user I/O (buttons, switches, status LEDs) and the USB-UART bridge to a UART service with four functions: a boot banner, byte echo, LED status and a debug probe bus for an ILA. It is the top of the synthesized design and the DUT of the top-level bench.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200 baud). Minimum 4.
- `HB_BIT`, default 26: heartbeat counter bit driven to an LED.
- `clk` input, 1 bit: single system clock. All logic is on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `user_btn` input, 4 bits: push buttons, asynchronous.
- `user_sw` input, 4 bits: slide switches, asynchronous.
- `status_led` output, 8 bits: LED drive.
- `uart_rxd_out` output, 1 bit: serial data to the host. Named from the bridge's side; this is the FPGA TX.
- `uart_txd_in` input, 1 bit: serial data from the host. This is the FPGA RX. Asynchronous.
- `ila_probe` output, 32 bits: debug bus. May be left unconnected.

## Operation
- **Input synchronization:** `user_btn`, `user_sw` and `uart_txd_in` each pass through a 2-flop synchronizer before use.
- **UART framing:** 8N1, LSB first. Start bit 0, stop bit 1, every bit lasts `CLKS_PER_BIT` cycles. The line idles at 1.
- **Boot banner:** after reset the TX sends 0x4A 0x50 0x55 0x0D 0x0A ("JPU\r\n") once, back-to-back. After the last byte it enters echo mode.
- **RX detection and sampling:** the RX detects a start bit as a 1→0 transition of the synchronized line while idle. It re-checks the start bit at mid-bit (`CLKS_PER_BIT/2`) and aborts if the line is 1. It samples each data bit at mid-bit.
- **RX stop bit:** the stop bit is sampled at mid-bit. If it is 1, the RX pulses `rx_valid` for one cycle. If it is 0, it pulses `frame_err` for one cycle, drops the byte, and waits until the line returns to 1 before it can detect another start (break handling).
- **Echo:** each valid RX byte updates `last_rx` and is loaded into a 1-entry echo holding register. TX takes the holding byte whenever TX is idle and the banner is finished. During the banner, received bytes are held, not lost.
- **Echo overflow:** if the holding register is already full when a new byte arrives, the new byte is dropped and `ovf` is pulsed.
- **Sticky flags:** `frame_err_s` and `ovf_s` set on their pulses. Synchronized `user_btn[0]` clears them; set wins if both happen in the same cycle.
- **Heartbeat:** a free-running counter of width `HB_BIT+1`.
- **status_led:**
  - `user_sw[0]`=1: `last_rx`.
  - Otherwise, `[7]`=heartbeat, `[6]`=`frame_err_s`, `[5]`=`ovf_s`, `[4]`=`tx_busy`, `[3:0]`=synchronized `user_btn`.
- **ila_probe:** `[7:0]`=current TX byte, `[15:8]`=`last_rx`, `[16]`=`tx_busy`, `[17]`=`rx_valid`, `[18]`=`frame_err`, `[19]`=`ovf`, `[20]`=banner done, `[31:21]`=0.

## Timing
- **Reset values:** `uart_rxd_out`=1, `status_led`=0, `ila_probe`=0. All counters, flags, `last_rx` and the holding register are cleared, and the banner index is set to 0.
- **Reset mid-frame:** TX returns to idle-high on the cycle after `rst` is sampled. The banner restarts once reset is released.
- **First start bit:** `uart_rxd_out` falls on the first rising edge with `rst`=0.
- **Byte duration:** each TX byte occupies exactly 10×`CLKS_PER_BIT` cycles. Consecutive bytes have no idle gap.
- **RX→TX echo latency:**
  - `rx_valid` asserts at the stop-bit mid-sample (RX start edge + synchronizer delay + 9.5 bit times).
  - If TX is idle, its start bit begins 1 cycle after `rx_valid`.
- **TX states:** IDLE → START → DATA(8) → STOP → IDLE, or back to START if another byte is pending.
- **RX states:** IDLE → START → DATA → STOP → IDLE or WAIT_HIGH.

## Structure
- Package `jpu_impl_pkg` holds:
  - the banner byte array and length (5),
  - the default `CLKS_PER_BIT`,
  - the TX and RX state enums,
  - the ila_probe bit-index localparams.
- One sub-module, `jpu_uart`, contains the TX and RX engines. The top contains the synchronizers, banner/echo arbitration, flags, heartbeat, and the LED and probe muxing.

## Test plan
- **Reset and idle:** hold `rst`=1 for 2 cycles with `CLKS_PER_BIT`=8 → `uart_rxd_out`=1, `status_led`=0, `ila_probe`=0.
- **Banner:** release reset with RX idle high → TX decodes 0x4A 0x50 0x55 0x0D 0x0A, 80 cycles per byte, then stays high. `ila_probe[20]`=1 after the banner.
- **Echo:** send 0xA5 on `uart_txd_in` after the banner → TX echoes 0xA5 starting 1 cycle after `rx_valid`. With `user_sw[0]`=1, `status_led`=0xA5.
- **Line stuck low:** hold `uart_txd_in`=0 from reset → exactly one `frame_err` pulse, no echo, `status_led[6]`=1 with switches at 0. Pressing `user_btn[0]` then clears it.
- **Overflow:** send 3 bytes back-to-back during the banner → the first is held and echoed after the banner, the second and third are dropped, `ovf_s`=1.
- **Heartbeat:** with `HB_BIT`=3, `status_led[7]` toggles every 8 cycles.
